// File: rtl/idu_ctrl_pkg.sv
// Shared definitions for the decode controller: ImmType codes, opcode
// constants, the ebreak encoding and the FSM state type.
package idu_ctrl_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_U    = 3'd1,
    IMM_J    = 3'd2,
    IMM_B    = 3'd3,
    IMM_S    = 3'd4,
    IMM_NONE = 3'd7
  } imm_type_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/idu_ctrl_if.sv
// Fetch-side and execute-side handshake bundle of the decode controller.
// master = the surrounding core (IFU/EXU side), slave = the controller.
interface idu_ctrl_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type,
           out_rs1, out_rs2, out_rd
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_imm, out_imm_type,
           out_rs1, out_rs2, out_rd
  );

endinterface

// File: rtl/idu_ctrl_immgen.sv
// Immediate generator: assembles the sign-extended immediate of an
// instruction from its encoding fields for the given ImmType.
module idu_ctrl_immgen
  import idu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_inst,
  input  imm_type_e       i_type,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;

  // Field scramble per format; the 32-bit result is then sign-extended to XLEN
  always_comb begin
    w_imm32 = 32'sd0;
    case (i_type)
      IMM_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_U:   w_imm32 = {i_inst[31:12], 12'h000};
      IMM_J:   w_imm32 = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20],
                          i_inst[30:21], 1'b0};
      IMM_B:   w_imm32 = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25],
                          i_inst[11:8], 1'b0};
      IMM_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_NONE: w_imm32 = 32'sd0;
      default: w_imm32 = 32'sd0;
    endcase
  end

  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/idu_ctrl.sv
// Decode-stage controller: accepts fetched instructions, classifies the
// opcode, registers the decoded bundle for the EXU and halts on ebreak/illegal.
module idu_ctrl
  import idu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  idu_ctrl_if.slave        bus,
  input  logic             flush,
  output logic             halt,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  state_e           r_state;
  logic             r_out_valid;
  logic [31:0]      r_out_inst;
  logic [XLEN-1:0]  r_out_pc;
  logic [XLEN-1:0]  r_out_imm;
  logic [2:0]       r_out_imm_type;
  logic [4:0]       r_out_rs1;
  logic [4:0]       r_out_rs2;
  logic [4:0]       r_out_rd;
  logic             r_illegal;
  logic [CNT_W-1:0] r_dec_count;

  imm_type_e        w_imm_type;
  logic             w_bad_op;
  logic [XLEN-1:0]  w_imm;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_ebreak;

  // Opcode to ImmType lookup; anything not listed is an illegal opcode
  always_comb begin
    w_imm_type = IMM_NONE;
    w_bad_op   = 1'b0;
    case (bus.in_inst[6:0])
      OP_LUI, OP_AUIPC:                     w_imm_type = IMM_U;
      OP_JAL:                               w_imm_type = IMM_J;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  w_imm_type = IMM_I;
      OP_BRANCH:                            w_imm_type = IMM_B;
      OP_STORE:                             w_imm_type = IMM_S;
      OP_REG:                               w_imm_type = IMM_NONE;
      default: begin
        w_imm_type = IMM_NONE;
        w_bad_op   = 1'b1;
      end
    endcase
  end

  idu_ctrl_immgen #(
    .XLEN (XLEN)
  ) u_immgen (
    .i_inst (bus.in_inst[31:7]),
    .i_type (w_imm_type),
    .o_imm  (w_imm)
  );

  // A drain and an accept may share a cycle, giving one instruction per cycle
  assign w_in_ready = (r_state == ST_RUN) && !flush
                      && (!r_out_valid || bus.out_ready);
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_ebreak   = (bus.in_inst == INST_EBREAK);

  // FSM plus all registered outputs; flush outranks both handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_out_valid    <= 1'b0;
      r_out_inst     <= 32'h0000_0000;
      r_out_pc       <= '0;
      r_out_imm      <= '0;
      r_out_imm_type <= 3'd0;
      r_out_rs1      <= 5'd0;
      r_out_rs2      <= 5'd0;
      r_out_rd       <= 5'd0;
      r_illegal      <= 1'b0;
      r_dec_count    <= '0;
    end else if (flush) begin
      r_state     <= ST_RUN;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_dec_count <= r_dec_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_xfer) begin
        r_out_inst     <= bus.in_inst;
        r_out_pc       <= bus.in_pc;
        r_out_imm      <= w_imm;
        r_out_imm_type <= w_imm_type;
        r_out_rs1      <= bus.in_inst[19:15];
        r_out_rs2      <= bus.in_inst[24:20];
        r_out_rd       <= bus.in_inst[11:7];
        if (w_bad_op) begin
          r_out_valid <= 1'b0;
          r_illegal   <= 1'b1;
          r_state     <= ST_HALT;
        end else begin
          // ebreak still reaches the EXU before the stage stops
          r_out_valid <= 1'b1;
          if (w_ebreak) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= r_state;
          end
        end
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_inst     = r_out_inst;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_imm      = r_out_imm;
  assign bus.out_imm_type = r_out_imm_type;
  assign bus.out_rs1      = r_out_rs1;
  assign bus.out_rs2      = r_out_rs2;
  assign bus.out_rd       = r_out_rd;
  assign halt             = (r_state == ST_HALT);
  assign illegal          = r_illegal;
  assign dec_count        = r_dec_count;

endmodule
